// File: rtl/mult_sequenciador_if.sv
// Valid/ready operand and result channels of the multiplier sequencer.
// The master drives operands and accepts results; the slave is the sequencer.
interface mult_sequenciador_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_produto;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_produto, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_produto, busy
    );
endinterface

// File: rtl/mult_sequenciador.sv
// Operand FIFO, run control and result register around a sequential shift-add
// multiplier that needs its operands held for CYCLES edges after its reset drops.
module mult_sequenciador #(
    parameter int WIDTH      = 16,
    parameter int CYCLES     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_sequenciador_if.slave   bus,
    output logic [WIDTH-1:0]     mult_multiplicando,
    output logic [WIDTH-1:0]     mult_multiplicador,
    output logic                 mult_reset,
    input  logic [2*WIDTH-1:0]   mult_produto
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [2*WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [PW:0]          count_r;
    logic [CW-1:0]        cnt_r;
    logic [WIDTH-1:0]     mult_a_r;
    logic [WIDTH-1:0]     mult_b_r;
    logic                 mult_reset_r;
    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   out_produto_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 start_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == '0);
    assign push_s  = bus.in_valid && !full_s;
    // Launch only when the result register is free or being drained this cycle.
    assign start_s = (state_r == S_IDLE) && !empty_s && (!out_valid_r || bus.out_ready);

    assign bus.in_ready        = !full_s;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_produto     = out_produto_r;
    assign bus.busy            = (state_r != S_IDLE) || !empty_s;
    assign mult_multiplicando  = mult_a_r;
    assign mult_multiplicador  = mult_b_r;
    assign mult_reset          = mult_reset_r;

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {bus.in_a, bus.in_b};
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (start_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, start_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register and run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                cnt_r <= '0;
            end else if (state_r == S_RUN) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_s = S_RUN;
                else         state_s = S_IDLE;
            end
            S_RUN: begin
                if (cnt_r == LAST_C) state_s = S_DONE;
                else                 state_s = S_RUN;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Operand registers and multiplier reset; reset is released only while operands are valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a_r     <= '0;
            mult_b_r     <= '0;
            mult_reset_r <= 1'b1;
        end else if (start_s) begin
            {mult_a_r, mult_b_r} <= fifo_mem_r[rd_ptr_r];
            mult_reset_r         <= 1'b0;
        end else if (state_r == S_DONE) begin
            mult_reset_r <= 1'b1;
        end
    end

    // Result register: captured on the edge that ends DONE, before the multiplier is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_produto_r <= '0;
        end else if (state_r == S_DONE) begin
            out_valid_r   <= 1'b1;
            out_produto_r <= mult_produto;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_sequenciador.sv
// Bench for mult_sequenciador: stand-in multiplier plus a transaction-level
// model of queueing, 34-cycle operation latency and result hand-off.
module tb_mult_sequenciador;
    localparam int WIDTH      = 16;
    localparam int CYCLES     = 32;
    localparam int FIFO_DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] mult_multiplicando;
    logic [15:0] mult_multiplicador;
    logic        mult_reset;
    logic [31:0] mult_produto;

    mult_sequenciador_if #(.WIDTH(WIDTH)) bus ();

    mult_sequenciador #(
        .WIDTH(WIDTH), .CYCLES(CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mult_multiplicando(mult_multiplicando),
        .mult_multiplicador(mult_multiplicador),
        .mult_reset(mult_reset),
        .mult_produto(mult_produto)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: correct product only after its CYCLES-th edge out of reset.
    int          m_cnt;
    logic [15:0] m_a, m_b;
    always @(posedge clk) begin
        if (mult_reset) begin
            m_cnt        <= 0;
            mult_produto <= 32'h0;
        end else begin
            if (m_cnt == 0) begin
                m_a <= mult_multiplicando;
                m_b <= mult_multiplicador;
            end
            m_cnt <= m_cnt + 1;
            if (m_cnt == CYCLES - 1) mult_produto <= {16'h0, m_a} * {16'h0, m_b};
            else                     mult_produto <= 32'hBAD0_0000 | 32'(m_cnt);
        end
    end

    // Reference model state.
    logic [31:0] in_q[$];
    bit          inflight;
    bit          ov_m;
    int          rem;
    logic [15:0] cur_a, cur_b;
    logic [31:0] res_val;
    bit          accepted;
    bit          new_res;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(bus.in_ready), 32'(in_q.size() < FIFO_DEPTH));
        check("busy", 32'(bus.busy), 32'(inflight || in_q.size() != 0));
        check("out_valid", 32'(bus.out_valid), 32'(ov_m));
        if (ov_m) check("out_produto", bus.out_produto, res_val);
        check("mult_reset", 32'(mult_reset), 32'(!inflight));
        if (inflight) begin
            check("mult_multiplicando", 32'(mult_multiplicando), 32'(cur_a));
            check("mult_multiplicador", 32'(mult_multiplicador), 32'(cur_b));
        end
    endtask

    // One clock: model decisions from pre-edge inputs, then compare post-edge outputs.
    task automatic tick();
        bit          push_m, pop_m, cons_m, res_m, pre_ov, pre_or;
        logic [31:0] entry, pair;
        pre_ov   = bus.out_valid;
        pre_or   = bus.out_ready;
        accepted = bus.in_valid && bus.in_ready;
        pair     = {bus.in_a, bus.in_b};
        push_m   = bus.in_valid && (in_q.size() < FIFO_DEPTH);
        cons_m   = ov_m && bus.out_ready;
        pop_m    = !inflight && (in_q.size() != 0) && (!ov_m || bus.out_ready);
        res_m    = inflight && (rem == 1);
        @(posedge clk);
        #1;
        if (cons_m) ov_m = 1'b0;
        if (res_m) begin
            ov_m     = 1'b1;
            res_val  = 32'(cur_a) * 32'(cur_b);
            inflight = 1'b0;
        end else if (inflight) begin
            rem--;
        end
        if (pop_m) begin
            entry    = in_q.pop_front();
            cur_a    = entry[31:16];
            cur_b    = entry[15:0];
            inflight = 1'b1;
            rem      = CYCLES + 1;
        end
        if (push_m) in_q.push_back(pair);
        new_res = bus.out_valid && (!pre_ov || pre_or);
        check_outputs();
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        in_q.delete();
        inflight = 1'b0;
        ov_m     = 1'b0;
        rem      = 0;
        res_val  = 32'h0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_produto", bus.out_produto, 32'd0);
        check("rst_mcand", 32'(mult_multiplicando), 32'd0);
        check("rst_mplier", 32'(mult_multiplicador), 32'd0);
        check("rst_mult_reset", 32'(mult_reset), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        do begin
            tick();
            k++;
        end while (!accepted && k < 200);
        check("send_accept", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n       = 0;
        new_res = 1'b0;
        while (!new_res && n < 200) begin
            tick();
            n++;
        end
        check("result_arrives", 32'(new_res), 32'd1);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (in_q.size() != 0 || inflight || ov_m) tick();
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.out_ready = 1'b1;
        #2;
        apply_reset();

        // 1: single operation latency and value
        send(16'd12, 16'd75);
        wait_result(n);
        check("t1_latency_from_push", 32'(n), 32'd34);
        check("t1_product", bus.out_produto, 32'd900);
        tick();
        check("t1_idle_mult_reset", 32'(mult_reset), 32'd1);
        drain();

        // 2: back-to-back products, 34 cycles apart
        send(16'd12, 16'd75);
        send(16'd16, 16'd5);
        send(16'hFFFF, 16'hFFFF);
        wait_result(n);
        check("t2_first", bus.out_produto, 32'd900);
        wait_result(n);
        check("t2_spacing1", 32'(n), 32'd34);
        check("t2_second", bus.out_produto, 32'd80);
        wait_result(n);
        check("t2_spacing2", 32'(n), 32'd34);
        check("t2_third", bus.out_produto, 32'hFFFE_0001);
        drain();

        // 3: backpressure fills the FIFO, then resumes in order
        bus.out_ready = 1'b0;
        send(16'd12, 16'd75);
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom));
        check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_full_no_accept", 32'(accepted), 32'd0);
        end
        wait_result(n);
        check("t3_held", bus.out_produto, 32'd900);
        repeat (10) tick();
        check("t3_idle_mult_reset", 32'(mult_reset), 32'd1);
        check("t3_held_stable", bus.out_produto, 32'd900);
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        check("t3_sixth_accept", 32'(accepted), 32'd1);
        drain();

        // 4: push and pop together at occupancy 3, then random traffic with pointer wrap
        bus.out_ready = 1'b0;
        send(16'($urandom), 16'($urandom));
        wait_result(n);
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom));
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'($urandom);
        bus.in_b      = 16'($urandom);
        bus.out_ready = 1'b1;
        tick();
        check("t4_push_at_3", 32'(accepted), 32'd1);
        check("t4_pop_at_3", 32'(mult_reset), 32'd0);
        for (int i = 0; i < 700; i++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_a      = 16'($urandom);
            bus.in_b      = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // 5: reset in the middle of a run discards everything
        send(16'($urandom), 16'($urandom));
        tick();
        repeat (15) tick();
        apply_reset();
        bus.out_ready = 1'b1;
        repeat (40) tick();
        send(16'd3, 16'd7);
        wait_result(n);
        check("t5_after_reset", bus.out_produto, 32'd21);
        drain();

        // 6: zero and one operands
        send(16'h0000, 16'h1234);
        wait_result(n);
        check("t6_zero", bus.out_produto, 32'h0000_0000);
        send(16'h0001, 16'hFFFF);
        wait_result(n);
        check("t6_one", bus.out_produto, 32'h0000_FFFF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_sequenciador.md
Name: mult_sequenciador

Overview:
Operand-feeding and result-collecting stage that sits directly around the 16x16 sequential shift-add multiplier. It buffers incoming operand pairs in a small FIFO and presents one pair to the multiplier. It holds those operands stable for the multiplier's fixed 32-clock run, controls the multiplier's reset, and captures the 32-bit product into an output register. The upstream and downstream sides both use valid/ready handshakes.

Parameters:
WIDTH, 16, operand width; the product is 2*WIDTH bits.
CYCLES, 32, number of multiplier clock edges from operand load to a valid product.
FIFO_DEPTH, 4, number of input operand-pair entries; must be a power of two and at least 2.

Ports:
Clk  in  1  rising-edge clock, shared with the multiplier.
Reset  in  1  asynchronous, active-low reset (0 = reset).
In_valid  in  1  an operand pair is offered.
In_ready  out  1  FIFO can accept the pair.
In_a  in  WIDTH  multiplicand.
In_b  in  WIDTH  multiplier.
Out_valid  out  1  Out_produto holds a result.
Out_ready  in  1  downstream accepts the result.
Out_produto  out  2*WIDTH  registered product.
Busy  out  1  FSM not in IDLE, or FIFO not empty.
Mult_multiplicando  out  WIDTH  to the multiplier's Multiplicando input.
Mult_multiplicador  out  WIDTH  to the multiplier's Multiplicador input.
Mult_reset  out  1  active-high reset to the multiplier.
Mult_produto  in  2*WIDTH  from the multiplier's Produto output.

Behaviour:
Reset values (applied asynchronously while Reset = 0):
- FIFO empty.
- FSM in IDLE, counter 0.
- Out_valid = 0, Out_produto = 0.
- Mult_multiplicando = 0, Mult_multiplicador = 0.
- Mult_reset = 1, Busy = 0.

Input FIFO:
- In_ready = !full.
- A push occurs on an edge where In_valid && In_ready.
- When full, In_ready = 0 even if a pop happens in the same cycle; there is no pass-through.
- Pop and push in the same cycle is allowed when not full.
- A pop requires the FIFO to be non-empty at the start of the cycle; there is no empty bypass.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Order is strictly first in, first out.

FSM states IDLE, RUN, DONE:
- IDLE: Mult_reset = 1.
  - Start condition: FIFO non-empty && (!Out_valid || Out_ready).
  - When the start condition holds, on that edge: pop the head entry into the Mult_multiplicando/Mult_multiplicador registers, clear the counter, and go to RUN.
- RUN: Mult_reset = 0; operands held constant.
  - The counter increments every edge.
  - At the edge where counter == CYCLES-1, go to DONE. RUN therefore lasts exactly CYCLES cycles, which gives the multiplier CYCLES edges: one load edge plus CYCLES-1 step edges.
- DONE: lasts one cycle; Mult_reset = 0.
  - On the edge ending DONE: Out_produto <= Mult_produto, Out_valid <= 1, go to IDLE.
  - Mult_reset rises after that edge. It must not rise earlier, because that would corrupt Produto before sampling.

Output register:
- Out_valid clears on an edge with Out_valid && Out_ready, unless DONE sets it on the same edge.
- The start condition guarantees the register is empty or draining when a new operation is launched, so DONE never overwrites an unconsumed result.
- Out_produto is stable while Out_valid && !Out_ready.

Latency and throughput:
- The pop edge is edge P; Out_valid = 1 after edge P+CYCLES+1 (P+33 with defaults).
- Back-to-back operation takes CYCLES+2 = 34 cycles per product (IDLE, RUN x32, DONE).

Arithmetic: unsigned. Out_produto = In_a * In_b, full 2*WIDTH bits, no truncation.

Reset mid-operation: any in-flight operation, FIFO contents and held result are discarded immediately, and Mult_reset is forced to 1 asynchronously.

Busy follows the definition given in the port list.

Test Plan:
1. Reset released, push (12,75), Out_ready = 1 -> Mult_multiplicando = 12 and Mult_multiplicador = 75 for 32 cycles; Out_valid rises exactly 33 edges after the pop edge with Out_produto = 900 (0x384); Mult_reset = 1 in IDLE.
2. Push (12,75), (16,5), (0xFFFF,0xFFFF) back-to-back -> results in order 900, 80, 0xFFFE0001; consecutive Out_valid rises are 34 cycles apart.
3. Out_ready = 0, push 6 pairs -> In_ready drops after the FIFO holds 4 entries (one pair already popped); Out_valid stays high with 900; FSM stays in IDLE with Mult_reset = 1; raising Out_ready resumes and all remaining results arrive in order.
4. Simultaneous push and pop at FIFO_DEPTH-1 occupancy, plus pointer wrap after 9 or more pushes -> no loss or duplication; the output sequence matches the input order.
5. Assert Reset = 0 at RUN counter = 15 -> all outputs immediately take their reset values; after release, no result appears; a new push of (3,7) yields 21.
6. Operands of 0 (0x0000 × 0x1234) and 1 (0x0001 × 0xFFFF) -> 0x00000000 and 0x0000FFFF.
